// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the character-LCD bus decoder.
package lcd_bus_pkg;

    localparam int unsigned SHADOW_DEPTH  = 32;
    localparam logic [7:0]  FILL_CHAR_DEF = 8'h20;
    localparam logic [6:0]  ROW0_BASE     = 7'h00;
    localparam logic [6:0]  ROW1_BASE     = 7'h40;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    typedef enum logic [2:0] {
        INS_NONE,
        INS_CLEAR,
        INS_HOME,
        INS_ENTRY,
        INS_DISPLAY,
        INS_SHIFT_FUNC,
        INS_CGRAM,
        INS_DDRAM
    } instr_cls_t;

    // Instruction class is selected by the highest set bit of the opcode.
    function automatic instr_cls_t classify(input logic [7:0] d);
        if (d[7])              return INS_DDRAM;
        else if (d[6])         return INS_CGRAM;
        else if (d[5] || d[4]) return INS_SHIFT_FUNC;
        else if (d[3])         return INS_DISPLAY;
        else if (d[2])         return INS_ENTRY;
        else if (d[1])         return INS_HOME;
        else if (d[0])         return INS_CLEAR;
        else                   return INS_NONE;
    endfunction

endpackage

// File: rtl/lcd_bus_decoder_if.sv
// LCD write bus plus shadow read port and decoder status signals.
interface lcd_bus_decoder_if;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [7:0] LCD_DATA;
    logic [4:0] RD_ADDR;
    logic [7:0] RD_CHAR;
    logic [4:0] CURSOR;
    logic       DISP_ON;
    logic       INC_MODE;
    logic       BUSY;
    logic       EVT_VALID;
    logic       EVT_RS;
    logic [7:0] EVT_DATA;
    logic       ERR;

    modport master (
        output LCD_RS, LCD_RW, LCD_EN, LCD_DATA, RD_ADDR,
        input  RD_CHAR, CURSOR, DISP_ON, INC_MODE, BUSY,
               EVT_VALID, EVT_RS, EVT_DATA, ERR
    );

    modport slave (
        input  LCD_RS, LCD_RW, LCD_EN, LCD_DATA, RD_ADDR,
        output RD_CHAR, CURSOR, DISP_ON, INC_MODE, BUSY,
               EVT_VALID, EVT_RS, EVT_DATA, ERR
    );
endinterface

// File: rtl/lcd_shadow_ram.sv
// 32x8 display shadow: one write port, one registered read port (read-before-write).
module lcd_shadow_ram
    import lcd_bus_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_we,
    input  logic [4:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [4:0] i_raddr,
    output logic [7:0] o_rdata
);
    logic [7:0] r_mem [SHADOW_DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_rdata <= '0;
        else       r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/lcd_bus_decoder.sv
// Receive-side decoder for the 8-bit character-LCD write bus with a 2x16 shadow.
module lcd_bus_decoder
    import lcd_bus_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_CHAR   = FILL_CHAR_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    lcd_bus_decoder_if.slave bus
);
    logic [SYNC_STAGES-1:0][10:0] r_sync;
    logic [10:0] w_sync_out;
    logic        r_en_prev, r_fall, r_rs, r_rw;
    logic [7:0]  r_data;
    state_t      r_state;
    logic [4:0]  r_clr_idx, r_cursor;
    logic        r_disp_on, r_inc_mode, r_busy, r_evt_valid, r_evt_rs, r_err;
    logic [7:0]  r_evt_data;
    instr_cls_t  w_cls;
    logic        w_row1, w_ddram_ok, w_accept, w_reject, w_we;
    logic [4:0]  w_waddr;
    logic [7:0]  w_wdata;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Synchronizers reset low, so an EN already low at release never looks like a fall.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync    <= '0;
            r_en_prev <= 1'b0;
            r_fall    <= 1'b0;
            r_rs      <= 1'b0;
            r_rw      <= 1'b0;
            r_data    <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0],
                          {bus.LCD_RS, bus.LCD_RW, bus.LCD_EN, bus.LCD_DATA}};
            r_en_prev <= w_sync_out[8];
            r_fall    <= r_en_prev & ~w_sync_out[8];
            if (r_en_prev && !w_sync_out[8]) begin
                r_rs   <= w_sync_out[10];
                r_rw   <= w_sync_out[9];
                r_data <= w_sync_out[7:0];
            end
        end
    end

    always_comb begin
        w_cls      = classify(r_data);
        w_row1     = (r_data[6:4] == ROW1_BASE[6:4]);
        w_ddram_ok = (r_data[6:4] == ROW0_BASE[6:4]) || w_row1;
        w_accept   = 1'b0;
        if (r_fall && r_state == ST_IDLE && !r_rw) begin
            if (r_rs) begin
                w_accept = 1'b1;
            end else begin
                case (w_cls)
                    INS_NONE, INS_CGRAM: w_accept = 1'b0;
                    INS_DDRAM:           w_accept = w_ddram_ok;
                    default:             w_accept = 1'b1;
                endcase
            end
        end
        w_reject = r_fall && !w_accept;
        w_we     = (r_state == ST_CLEAR) || (w_accept && r_rs);
        w_waddr  = (r_state == ST_CLEAR) ? r_clr_idx : r_cursor;
        w_wdata  = (r_state == ST_CLEAR) ? FILL_CHAR : r_data;
    end

    // Reset lands in CLEAR so the shadow fill restarts from index 0 on every release.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_CLEAR;
            r_clr_idx   <= '0;
            r_cursor    <= '0;
            r_disp_on   <= 1'b0;
            r_inc_mode  <= 1'b1;
            r_busy      <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_rs    <= 1'b0;
            r_evt_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_busy      <= (r_state == ST_CLEAR);
            r_evt_valid <= w_accept;
            r_err       <= w_reject;
            if (w_accept) begin
                r_evt_rs   <= r_rs;
                r_evt_data <= r_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (r_rs) begin
                            r_cursor <= r_inc_mode ? r_cursor + 5'd1 : r_cursor - 5'd1;
                        end else begin
                            case (w_cls)
                                INS_CLEAR: begin
                                    r_cursor   <= '0;
                                    r_inc_mode <= 1'b1;
                                    r_clr_idx  <= '0;
                                    r_state    <= ST_CLEAR;
                                end
                                INS_HOME:    r_cursor   <= '0;
                                INS_ENTRY:   r_inc_mode <= r_data[1];
                                INS_DISPLAY: r_disp_on  <= r_data[2];
                                INS_DDRAM:   r_cursor   <= {w_row1, r_data[3:0]};
                                default: ;
                            endcase
                        end
                    end
                end
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 5'd1;
                    if (r_clr_idx == 5'(SHADOW_DEPTH - 1)) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    lcd_shadow_ram u_ram (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (bus.RD_ADDR),
        .o_rdata (bus.RD_CHAR)
    );

    assign bus.CURSOR    = r_cursor;
    assign bus.DISP_ON   = r_disp_on;
    assign bus.INC_MODE  = r_inc_mode;
    assign bus.BUSY      = r_busy;
    assign bus.EVT_VALID = r_evt_valid;
    assign bus.EVT_RS    = r_evt_rs;
    assign bus.EVT_DATA  = r_evt_data;
    assign bus.ERR       = r_err;
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed vector bench for lcd_bus_decoder.
module tb_lcd_bus_decoder;
    localparam int unsigned SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_bus_decoder_if u_if ();

    lcd_bus_decoder #(
        .SYNC_STAGES (SYNC),
        .FILL_CHAR   (8'h20)
    ) u_dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (u_if.slave)
    );

    int total = 0;
    int bad   = 0;
    int n_evt = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (u_if.EVT_VALID) n_evt++;
        if (u_if.ERR)       n_err++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        u_if.LCD_RS = rs; u_if.LCD_RW = rw; u_if.LCD_DATA = d;
        repeat (2) @(negedge clk);
        u_if.LCD_EN = 1'b0;
        repeat (8) @(negedge clk);
        u_if.LCD_EN = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] v);
        @(negedge clk);
        u_if.RD_ADDR = a;
        @(posedge clk);
        #1 v = u_if.RD_CHAR;
    endtask

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] data;
        int         evt;
        int         err;
        int         cur;
        int         inc;
        int         disp;
        logic [4:0] ra;
        logic [7:0] rv;
    } vec_t;

    vec_t vt[19];

    task automatic wait_not_busy(input string name);
        int c;
        c = 0;
        while (u_if.BUSY && c < 100) begin
            @(negedge clk);
            c++;
        end
        check(name, u_if.BUSY, 0);
    endtask

    task automatic check_all_fill(input string name);
        logic [7:0] v;
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), v);
            check($sformatf("%s[%0d]", name, a), v, 8'h20);
        end
    endtask

    initial begin
        int e0, r0, cnt, lat;
        logic [7:0] v;

        vt[0]  = '{1'b1, 1'b0, 8'h48, 1, 0,  1, 1, 0,  5'd0, 8'h48};
        vt[1]  = '{1'b1, 1'b0, 8'h69, 1, 0,  2, 1, 0,  5'd1, 8'h69};
        vt[2]  = '{1'b0, 1'b0, 8'h0C, 1, 0,  2, 1, 1,  5'd0, 8'h48};
        vt[3]  = '{1'b0, 1'b0, 8'hC5, 1, 0, 21, 1, 1, 5'd21, 8'h20};
        vt[4]  = '{1'b1, 1'b0, 8'h41, 1, 0, 22, 1, 1, 5'd21, 8'h41};
        vt[5]  = '{1'b0, 1'b0, 8'h95, 0, 1, 22, 1, 1, 5'd22, 8'h20};
        vt[6]  = '{1'b0, 1'b0, 8'h00, 0, 1, 22, 1, 1,  5'd2, 8'h20};
        vt[7]  = '{1'b0, 1'b0, 8'h40, 0, 1, 22, 1, 1,  5'd1, 8'h69};
        vt[8]  = '{1'b0, 1'b0, 8'h18, 1, 0, 22, 1, 1,  5'd3, 8'h20};
        vt[9]  = '{1'b0, 1'b0, 8'h02, 1, 0,  0, 1, 1,  5'd0, 8'h48};
        vt[10] = '{1'b0, 1'b0, 8'h04, 1, 0,  0, 0, 1, 5'd31, 8'h20};
        vt[11] = '{1'b1, 1'b0, 8'h58, 1, 0, 31, 0, 1,  5'd0, 8'h58};
        vt[12] = '{1'b0, 1'b0, 8'h06, 1, 0, 31, 1, 1, 5'd31, 8'h20};
        vt[13] = '{1'b0, 1'b0, 8'h8F, 1, 0, 15, 1, 1, 5'd15, 8'h20};
        vt[14] = '{1'b1, 1'b0, 8'h59, 1, 0, 16, 1, 1, 5'd15, 8'h59};
        vt[15] = '{1'b1, 1'b1, 8'h33, 0, 1, 16, 1, 1, 5'd16, 8'h20};
        vt[16] = '{1'b0, 1'b0, 8'h08, 1, 0, 16, 1, 0, 5'd16, 8'h20};
        vt[17] = '{1'b0, 1'b0, 8'hD0, 0, 1, 16, 1, 0, 5'd16, 8'h20};
        vt[18] = '{1'b0, 1'b0, 8'hCF, 1, 0, 31, 1, 0, 5'd31, 8'h20};

        u_if.LCD_RS = 1'b0; u_if.LCD_RW = 1'b0; u_if.LCD_EN = 1'b1;
        u_if.LCD_DATA = 8'h00; u_if.RD_ADDR = 5'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst cursor",  u_if.CURSOR, 0);
        check("rst inc",     u_if.INC_MODE, 1);
        check("rst disp",    u_if.DISP_ON, 0);
        check("rst busy",    u_if.BUSY, 0);
        check("rst evt",     u_if.EVT_VALID, 0);
        check("rst evtdata", u_if.EVT_DATA, 0);
        check("rst err",     u_if.ERR, 0);
        check("rst rdchar",  u_if.RD_CHAR, 0);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("busy after release", u_if.BUSY, 1);
        cnt = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (u_if.BUSY) cnt++;
            else break;
        end
        check("reset busy cycles", cnt, 32);
        check_all_fill("reset fill");

        for (int i = 0; i < 19; i++) begin
            e0 = n_evt; r0 = n_err;
            strobe(vt[i].rs, vt[i].rw, vt[i].data);
            check($sformatf("v%0d evt", i),    n_evt - e0, vt[i].evt);
            check($sformatf("v%0d err", i),    n_err - r0, vt[i].err);
            check($sformatf("v%0d cursor", i), u_if.CURSOR, vt[i].cur);
            check($sformatf("v%0d inc", i),    u_if.INC_MODE, vt[i].inc);
            check($sformatf("v%0d disp", i),   u_if.DISP_ON, vt[i].disp);
            if (vt[i].evt != 0) begin
                check($sformatf("v%0d evt_data", i), u_if.EVT_DATA, vt[i].data);
                check($sformatf("v%0d evt_rs", i),   u_if.EVT_RS, vt[i].rs);
            end
            rd(vt[i].ra, v);
            check($sformatf("v%0d shadow[%0d]", i, vt[i].ra), v, vt[i].rv);
        end

        // Clear display while decrementing, then a data strobe during the clear.
        strobe(1'b0, 1'b0, 8'h04);
        check("pre-clear inc", u_if.INC_MODE, 0);
        e0 = n_evt; r0 = n_err;
        strobe(1'b0, 1'b0, 8'h01);
        check("clear evt",      n_evt - e0, 1);
        check("clear evt_data", u_if.EVT_DATA, 8'h01);
        check("clear busy",     u_if.BUSY, 1);
        check("clear cursor",   u_if.CURSOR, 0);
        check("clear inc",      u_if.INC_MODE, 1);
        e0 = n_evt; r0 = n_err;
        strobe(1'b1, 1'b0, 8'h7A);
        check("busy strobe err", n_err - r0, 1);
        check("busy strobe evt", n_evt - e0, 0);
        check("busy strobe cursor", u_if.CURSOR, 0);
        wait_not_busy("clear finishes");
        check_all_fill("clear fill");

        // Reset while EN is held low: nothing may be reported after release.
        strobe(1'b1, 1'b0, 8'h31);
        @(negedge clk);
        u_if.LCD_RS = 1'b1; u_if.LCD_DATA = 8'h77; u_if.LCD_EN = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        e0 = n_evt; r0 = n_err;
        rst = 1'b0;
        repeat (45) @(negedge clk);
        u_if.LCD_EN = 1'b1;
        repeat (5) @(negedge clk);
        check("rst-low evt", n_evt - e0, 0);
        check("rst-low err", n_err - r0, 0);
        check("rst-low cursor", u_if.CURSOR, 0);
        check("rst-low busy", u_if.BUSY, 0);
        rd(5'd0, v);
        check("rst-low shadow[0]", v, 8'h20);

        // Latency: count posedges from the first one that samples EN low.
        @(negedge clk);
        u_if.LCD_RS = 1'b0; u_if.LCD_RW = 1'b0; u_if.LCD_DATA = 8'h18;
        repeat (2) @(negedge clk);
        u_if.LCD_EN = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (u_if.EVT_VALID || u_if.ERR) begin
                lat = k;
                break;
            end
        end
        check("latency edge", lat, 1 + SYNC + 1);
        check("latency evt", u_if.EVT_VALID, 1);
        @(negedge clk);
        u_if.LCD_EN = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
